// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its lane aligner.
package lsu_pkg;
    localparam int unsigned LSU_ADDR_W = 7;
    localparam int unsigned LSU_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;
endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: sub-word store merge and load extract/extend.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [LSU_DATA_W-1:0] word,
    input  logic [LSU_DATA_W-1:0] wdata,
    input  logic [1:0]            size,
    input  logic [1:0]            offset,
    input  logic                  sign_ext,
    output logic [LSU_DATA_W-1:0] merged_c,
    output logic [LSU_DATA_W-1:0] extracted_c
);
    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_lsb = {offset, 3'b000};
    assign half_lsb = {offset[1], 4'b0000};
    assign byte_v   = word[byte_lsb +: 8];
    assign half_v   = word[half_lsb +: 16];

    // Replace the addressed lane of the read word with the store data.
    always_comb begin
        merged_c = word;
        case (size)
            SZ_BYTE: merged_c[byte_lsb +: 8]  = wdata[7:0];
            SZ_HALF: merged_c[half_lsb +: 16] = wdata[15:0];
            SZ_WORD: merged_c = wdata;
            default: merged_c = word;
        endcase
    end

    always_comb begin
        extracted_c = '0;
        case (size)
            SZ_BYTE: extracted_c = {{24{sign_ext & byte_v[7]}}, byte_v};
            SZ_HALF: extracted_c = {{16{sign_ext & half_v[15]}}, half_v};
            SZ_WORD: extracted_c = word;
            default: extracted_c = '0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store controller for a single-port word memory with combinational read.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = LSU_DATA_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_read_data
);
    state_e            state, state_n;
    logic              we_q, signed_q;
    logic [1:0]        size_q, offset_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_we_q;

    logic              latch;
    logic              illegal_c;
    logic              resp_valid_n, resp_error_n, mem_we_n;
    logic [DATA_W-1:0] resp_rdata_n, mem_write_data_n;
    logic [ADDR_W-1:0] mem_address_n;
    logic [DATA_W-1:0] merged_c, extracted_c;

    lsu_lane_align u_align (
        .word        (mem_read_data),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (offset_q),
        .sign_ext    (signed_q),
        .merged_c    (merged_c),
        .extracted_c (extracted_c)
    );

    assign illegal_c = (req_size == 2'b11)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    assign req_ready = (state == IDLE) && !reset;
    // A write already launched must not reach memory once reset is raised.
    assign mem_we    = mem_we_q && !reset;

    always_comb begin
        state_n          = state;
        latch            = 1'b0;
        resp_valid_n     = 1'b0;
        resp_error_n     = 1'b0;
        resp_rdata_n     = '0;
        mem_we_n         = 1'b0;
        mem_address_n    = mem_address;
        mem_write_data_n = mem_write_data;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    latch         = 1'b1;
                    mem_address_n = req_addr[ADDR_W+1:2];
                    if (illegal_c) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_error_n = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_n          = WR;
                        mem_we_n         = 1'b1;
                        mem_write_data_n = req_wdata;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_n          = WR;
                    mem_we_n         = 1'b1;
                    mem_write_data_n = merged_c;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = extracted_c;
                end
            end
            WR: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            signed_q       <= 1'b0;
            size_q         <= 2'b00;
            offset_q       <= 2'b00;
            wdata_q        <= '0;
            mem_we_q       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= '0;
        end else begin
            state          <= state_n;
            mem_we_q       <= mem_we_n;
            mem_address    <= mem_address_n;
            mem_write_data <= mem_write_data_n;
            resp_valid     <= resp_valid_n;
            resp_error     <= resp_error_n;
            resp_rdata     <= resp_rdata_n;
            if (latch) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                size_q   <= req_size;
                offset_q <= req_addr[1:0];
                wdata_q  <= req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a cycle-level reference model and memory.
module tb_load_store_unit;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_we;
    logic [DATA_W-1:0] mem_read_data;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_we(mem_we),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Data memory: combinational read, write at the clock edge.
    logic [31:0] mem [0:127];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mem_we) mem[mem_address] <= mem_write_data;
    end

    function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [1:0] sz,
                                              input int off, input logic sg);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input int off);
        logic [31:0] m;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * off;
            m  = 32'hFF << sh;
        end else if (sz == 2'd1) begin
            sh = 16 * (off / 2);
            m  = 32'hFFFF << sh;
        end else begin
            sh = 0;
            m  = 32'hFFFF_FFFF;
        end
        return (old & ~m) | ((wd << sh) & m);
    endfunction

    // Reference model: predicts response/write cycles and values from each accept.
    logic [31:0] ref_mem [0:127];
    int          resp_at = -1;
    int          we_at = -1;
    int          busy_until = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_wdata = '0;
    logic [6:0]  exp_waddr = '0;
    logic        exp_err = 1'b0;
    int          acc_q[$];
    int          n_pulse = 0;

    always @(negedge clk) begin : model
        logic exp_ready;
        logic exp_rv;
        logic exp_we;
        logic bad;
        int   off;
        int   wi;
        int   we_lat;
        if (pre_we) ref_mem[pre_idx] = pre_val;
        if (cyc >= 1) begin
            exp_ready = !reset && (cyc > busy_until);
            exp_rv    = (cyc == resp_at);
            exp_we    = !reset && (cyc == we_at);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (resp_valid) n_pulse++;
            if (exp_rv && resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_error", 32'(resp_error), 32'(exp_err));
            end
            if (exp_we && mem_we) begin
                chk("mem_address", 32'(mem_address), 32'(exp_waddr));
                chk("mem_write_data", mem_write_data, exp_wdata);
                ref_mem[exp_waddr] = exp_wdata;
            end
            if (reset) begin
                resp_at    = -1;
                we_at      = -1;
                busy_until = cyc;
            end else if (req_valid && exp_ready) begin
                acc_q.push_back(cyc);
                off       = int'(req_addr) % 4;
                wi        = int'(req_addr) / 4;
                bad       = (req_size == 2'd3) || (req_size == 2'd1 && (off % 2) != 0)
                         || (req_size == 2'd2 && off != 0);
                exp_err   = bad;
                exp_rdata = '0;
                if (bad) begin
                    resp_at = cyc + 1;
                end else if (!req_we) begin
                    resp_at   = cyc + 2;
                    exp_rdata = f_extract(ref_mem[wi], req_size, off, req_signed);
                end else begin
                    we_lat    = (req_size == 2'd2) ? 1 : 2;
                    we_at     = cyc + we_lat;
                    resp_at   = cyc + we_lat + 1;
                    exp_waddr = 7'(wi);
                    exp_wdata = f_merge(ref_mem[wi], req_wdata, req_size, off);
                end
                busy_until = resp_at;
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        @(posedge clk); #1;
        pre_we  = 1'b1;
        pre_idx = 7'(idx);
        pre_val = val;
        @(posedge clk); #1;
        pre_we  = 1'b0;
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [8:0] a, input logic [31:0] wd);
        int n;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 10);
        if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'd1);
        rd  = resp_rdata;
        er  = resp_error;
        lat = n;
    endtask

    task automatic do_req(input string nm, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [8:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        send(we, sz, sg, a, wd);
        wait_resp(rd, er, lat);
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        int a0;
        int p0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Word store then word load
        do_req("st_word", 1'b1, 2'b10, 1'b0, 9'h010, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        chk("mem4_word", mem[4], 32'hDEAD_BEEF);
        do_req("ld_word", 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);

        // Byte store read-modify-write
        preload(4, 32'h1122_3344);
        do_req("st_byte", 1'b1, 2'b00, 1'b0, 9'h012, 32'h0000_00AB, 3, 32'h0, 1'b0);
        chk("mem4_byte", mem[4], 32'h11AB_3344);
        do_req("ld_word4", 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 2, 32'h11AB_3344, 1'b0);

        // Sub-word loads with extension
        preload(5, 32'h80FF_7F01);
        do_req("ld_sb16", 1'b0, 2'b00, 1'b1, 9'h016, 32'h0, 2, 32'hFFFF_FFFF, 1'b0);
        do_req("ld_ub17", 1'b0, 2'b00, 1'b0, 9'h017, 32'h0, 2, 32'h0000_0080, 1'b0);
        do_req("ld_sh14", 1'b0, 2'b01, 1'b1, 9'h014, 32'h0, 2, 32'h0000_7F01, 1'b0);
        do_req("ld_sh16", 1'b0, 2'b01, 1'b1, 9'h016, 32'h0, 2, 32'hFFFF_80FF, 1'b0);

        // Misaligned and illegal requests
        do_req("err_ld13", 1'b0, 2'b10, 1'b0, 9'h013, 32'h0, 1, 32'h0, 1'b1);
        do_req("err_sh15", 1'b1, 2'b01, 1'b0, 9'h015, 32'hFFFF_FFFF, 1, 32'h0, 1'b1);
        do_req("err_sz3", 1'b0, 2'b11, 1'b0, 9'h010, 32'h0, 1, 32'h0, 1'b1);
        chk("mem4_after_err", mem[4], 32'h11AB_3344);
        chk("mem5_after_err", mem[5], 32'h80FF_7F01);

        // Upper-half store and readback
        preload(6, 32'hAAAA_AAAA);
        do_req("st_half", 1'b1, 2'b01, 1'b0, 9'h01A, 32'hFFFF_1234, 3, 32'h0, 1'b0);
        chk("mem6_half", mem[6], 32'h1234_AAAA);
        do_req("ld_uh1a", 1'b0, 2'b01, 1'b0, 9'h01A, 32'h0, 2, 32'h0000_1234, 1'b0);

        // Reset during the read phase of a byte store
        send(1'b1, 2'b00, 1'b0, 9'h012, 32'h0000_0055);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("mem4_after_rst", mem[4], 32'h11AB_3344);

        // Back-to-back word loads with req_valid held
        a0 = acc_q.size();
        p0 = n_pulse;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 9'h010;
        repeat (7) @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_accepts", 32'(acc_q.size() - a0), 32'd3);
        if (acc_q.size() - a0 >= 3) begin
            chk("b2b_gap1", 32'(acc_q[a0+1] - acc_q[a0]), 32'd3);
            chk("b2b_gap2", 32'(acc_q[a0+2] - acc_q[a0+1]), 32'd3);
        end
        chk("b2b_pulses", 32'(n_pulse - p0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator-side controller for the single-port, word-addressed data memory. It accepts byte/halfword/word load and store requests from the CPU datapath using a valid/ready handshake and drives the memory's address, write-data and write-enable lines. It performs sign/zero extension on loads and read-modify-write for sub-word stores. It returns one response pulse per request and flags misaligned accesses without touching memory.

Parameters:
ADDR_W, 7, word-address width of the data memory (128 words)
DATA_W, 32, memory word width; fixed at 32 (4 byte lanes)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend on load; ignored for stores
req_addr  in  ADDR_W+2  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_W  load result; 0 for stores and errors
resp_error  out  1  misaligned or illegal size, valid with resp_valid
mem_address  out  ADDR_W  word address to memory
mem_write_data  out  DATA_W  write word to memory
mem_we  out  1  memory write enable
mem_read_data  in  DATA_W  memory read word; combinational in mem_address

Behaviour:
- Reset is synchronous and active-high on clock clk.
- Memory contract: read is combinational, so mem_read_data reflects mem_address in the same cycle. Write occurs at the posedge while mem_we=1.
- Reset: state IDLE. All internal registers are 0. resp_valid=0, resp_error=0, resp_rdata=0, mem_we=0, mem_address=0, mem_write_data=0. req_ready=0 while reset is high.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/signed/addr/wdata.
  - Next state:
    - Illegal size, or half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with error=1.
    - Load -> RD.
    - Word store -> WR.
    - Byte or half store -> RD.
- RD:
  - mem_address = latched addr[ADDR_W+1:2], mem_we=0.
  - Capture mem_read_data into word_q at the edge.
  - Load -> RESP. Sub-word store -> WR.
- WR:
  - mem_we=1 for exactly this one cycle.
  - mem_write_data = merged word:
    - word store: wdata
    - byte store: word_q with lane addr[1:0] replaced by wdata[7:0]
    - half store: word_q with half addr[1] replaced by wdata[15:0]
  - Next state RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - resp_rdata = extracted load data (zero for stores and errors).
  - Next state IDLE. No response backpressure.
- Lane rules (little-endian):
  - Byte k occupies bits [8k+7:8k]. Half h occupies bits [16h+15:16h].
  - Loads zero- or sign-extend to 32 bits per req_signed.
- Latency from accept edge to the resp_valid cycle:
  - error: 1
  - load: 2
  - word store: 2
  - sub-word store: 3
- Throughput: req_ready is high only in IDLE. The next request is accepted the cycle after RESP.
- Outside WR, mem_we=0. mem_address/mem_write_data hold the latched values (0 after reset).
- Reset mid-operation: return to IDLE the same edge. No mem_we is asserted in any cycle where reset=1, and no resp_valid is issued for the aborted request.
- Address range: the full byte-address space maps to 128 words; no out-of-range case exists.

Decomposition:
- Package lsu_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (IDLE, RD, WR, RESP)
  - ADDR_W default constant
- One combinational sub-module, lsu_lane_align, covers both lane functions:
  - merge: word_q, wdata, size, offset -> merged word
  - extract: word, size, offset, signed -> extended result
- The FSM, request registers and handshake live in load_store_unit.

Test Plan:
- Word store 0xDEADBEEF at 0x010, then word load at 0x010 -> mem_we high exactly 1 cycle with mem_address=4, data=0xDEADBEEF; store resp at cycle 2; load resp at cycle 2 returns 0xDEADBEEF, error=0.
- Word 4 preloaded 0x11223344; byte store 0xAB at 0x012 -> RD then WR writing 0x11AB3344; resp at cycle 3; word 4 reads back 0x11AB3344.
- Word 5 preloaded 0x80FF7F01:
  - signed byte 0x16 -> 0xFFFFFFFF
  - unsigned byte 0x17 -> 0x00000080
  - signed half 0x14 -> 0x00007F01
  - signed half 0x16 -> 0xFFFF80FF
- Word load at 0x013, half store at 0x015, and size=11 -> each gives resp_valid at cycle 1 with error=1 and rdata=0; mem_we never asserts; memory unchanged.
- Byte store to 0x012 with reset asserted during RD (memory model not on reset) -> no mem_we, no resp_valid; req_ready=1 the first cycle after reset drops; word 4 unchanged.
- req_valid held high with 3 back-to-back word loads -> req_ready low in RD/RESP; accepts at cycles 0, 3 and 6; three resp_valid pulses, each exactly 1 cycle.
